// File: rtl/life_support_pkg.sv
// Shared types and default constants for the life-support controller and
// its hysteresis sub-block.
package life_support_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_REG   = 2'd2,
        ST_ALARM = 2'd3
    } ls_state_t;

    localparam int LS_N         = 5;
    localparam int LS_SH_INIT   = 24;
    localparam int LS_TP_INIT   = 31;
    localparam int LS_SH_LO     = 8;
    localparam int LS_SH_HI     = 20;
    localparam int LS_TP_LO     = 10;
    localparam int LS_TP_HI     = 22;
    localparam int LS_ALARM_CYC = 4;

endpackage

// File: rtl/life_support_ctrl_hyst.sv
// Single-channel hysteresis requester: raises req below LO, drops it at or
// above HI, holds in between. clr wins over en.
module hyst_ctl
    import life_support_pkg::*;
#(
    parameter int N  = LS_N,
    parameter int LO = LS_SH_LO,
    parameter int HI = LS_SH_HI
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] lvl,
    output logic         req
);

    localparam logic [N-1:0] LO_V = N'(LO);
    localparam logic [N-1:0] HI_V = N'(HI);

    logic req_q;
    logic req_d;

    always_comb begin
        req_d = req_q;
        if (clr) begin
            req_d = 1'b0;
        end else if (en) begin
            if (lvl < LO_V) begin
                req_d = 1'b1;
            end else if (lvl >= HI_V) begin
                req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    assign req = req_q;

endmodule

// File: rtl/life_support_ctrl.sv
// Closed-loop command side of the shield/temperature counter: start-up preset
// load, hysteresis regulation and a latched zero-level alarm.
module life_support_ctrl
    import life_support_pkg::*;
#(
    parameter int N         = LS_N,
    parameter int SH_INIT   = LS_SH_INIT,
    parameter int TP_INIT   = LS_TP_INIT,
    parameter int SH_LO     = LS_SH_LO,
    parameter int SH_HI     = LS_SH_HI,
    parameter int TP_LO     = LS_TP_LO,
    parameter int TP_HI     = LS_TP_HI,
    parameter int ALARM_CYC = LS_ALARM_CYC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         ack,
    input  logic [N-1:0] shield_lvl,
    input  logic [N-1:0] temp_lvl,
    output logic         pwr,
    output logic         ld,
    output logic         def,
    output logic         sth,
    output logic [N-1:0] shield_pre,
    output logic [N-1:0] temp_pre,
    output logic         alarm,
    output logic [1:0]   state
);

    localparam int            CW        = $clog2(ALARM_CYC + 1);
    localparam logic [CW-1:0] FAULT_MAX = CW'(ALARM_CYC);
    localparam logic [N-1:0]  SH_LO_V   = N'(SH_LO);
    localparam logic [N-1:0]  TP_LO_V   = N'(TP_LO);
    localparam logic [N-1:0]  SH_INIT_V = N'(SH_INIT);
    localparam logic [N-1:0]  TP_INIT_V = N'(TP_INIT);

    ls_state_t     state_q;
    ls_state_t     state_d;
    logic [CW-1:0] fault_q;
    logic [CW-1:0] fault_d;
    logic          pwr_q;
    logic          pwr_d;
    logic          ld_q;
    logic          ld_d;
    logic          alarm_q;
    logic          alarm_d;
    logic [N-1:0]  shield_pre_q;
    logic [N-1:0]  shield_pre_d;
    logic [N-1:0]  temp_pre_q;
    logic [N-1:0]  temp_pre_d;

    logic any_zero;
    logic levels_ok;
    logic hyst_clr;
    logic hyst_en;
    logic def_req;
    logic sth_req;

    assign any_zero  = (shield_lvl == '0) || (temp_lvl == '0);
    assign levels_ok = (shield_lvl >= SH_LO_V) && (temp_lvl >= TP_LO_V);

    // Fault counter only runs in REG; every other state leaves it cleared.
    always_comb begin
        fault_d = '0;
        if (state_q == ST_REG && any_zero) begin
            fault_d = (fault_q == FAULT_MAX) ? fault_q : fault_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF:   state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_REG;
                ST_REG:   state_d = (fault_d == FAULT_MAX) ? ST_ALARM : ST_REG;
                ST_ALARM: state_d = (ack && levels_ok) ? ST_REG : ST_ALARM;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        pwr_d        = 1'b0;
        ld_d         = 1'b0;
        alarm_d      = 1'b0;
        shield_pre_d = '0;
        temp_pre_d   = '0;
        unique case (state_d)
            ST_OFF: begin
            end
            ST_LOAD: begin
                ld_d         = 1'b1;
                shield_pre_d = SH_INIT_V;
                temp_pre_d   = TP_INIT_V;
            end
            ST_REG: begin
                pwr_d = 1'b1;
            end
            ST_ALARM: begin
                pwr_d   = 1'b1;
                alarm_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr_q        <= 1'b0;
            ld_q         <= 1'b0;
            alarm_q      <= 1'b0;
            shield_pre_q <= '0;
            temp_pre_q   <= '0;
        end else begin
            pwr_q        <= pwr_d;
            ld_q         <= ld_d;
            alarm_q      <= alarm_d;
            shield_pre_q <= shield_pre_d;
            temp_pre_q   <= temp_pre_d;
        end
    end

    // Requesters sit at zero outside REG, so leaving ALARM re-evaluates from 0.
    assign hyst_en  = (state_d == ST_REG);
    assign hyst_clr = (state_d != ST_REG) || (state_q == ST_LOAD);

    hyst_ctl #(
        .N  (N),
        .LO (SH_LO),
        .HI (SH_HI)
    ) u_hyst_shield (
        .clk (clk),
        .rst (rst),
        .clr (hyst_clr),
        .en  (hyst_en),
        .lvl (shield_lvl),
        .req (def_req)
    );

    hyst_ctl #(
        .N  (N),
        .LO (TP_LO),
        .HI (TP_HI)
    ) u_hyst_temp (
        .clk (clk),
        .rst (rst),
        .clr (hyst_clr),
        .en  (hyst_en),
        .lvl (temp_lvl),
        .req (sth_req)
    );

    assign pwr        = pwr_q;
    assign ld         = ld_q;
    assign alarm      = alarm_q;
    assign def        = def_req | alarm_q;
    assign sth        = sth_req | alarm_q;
    assign shield_pre = shield_pre_q;
    assign temp_pre   = temp_pre_q;
    assign state      = state_q;

endmodule

// File: tb/tb_life_support_ctrl.sv
// Bench for life_support_ctrl: directed start-up/hysteresis/alarm steps and a
// randomized phase, all checked against a behavioural model of the controller.
module tb_life_support_ctrl;

    localparam int N         = 5;
    localparam int SH_INIT   = 24;
    localparam int TP_INIT   = 31;
    localparam int SH_LO     = 8;
    localparam int SH_HI     = 20;
    localparam int TP_LO     = 10;
    localparam int TP_HI     = 22;
    localparam int ALARM_CYC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         ack;
    logic [N-1:0] shield_lvl;
    logic [N-1:0] temp_lvl;
    logic         pwr;
    logic         ld;
    logic         def;
    logic         sth;
    logic [N-1:0] shield_pre;
    logic [N-1:0] temp_pre;
    logic         alarm;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode name (0 off, 1 load, 2 regulate, 3 alarm),
    // count of consecutive zero-level cycles, and the two hysteresis requests.
    int m_mode;
    int m_zero_run;
    bit m_def;
    bit m_sth;

    always #5 clk = ~clk;

    life_support_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ack        (ack),
        .shield_lvl (shield_lvl),
        .temp_lvl   (temp_lvl),
        .pwr        (pwr),
        .ld         (ld),
        .def        (def),
        .sth        (sth),
        .shield_pre (shield_pre),
        .temp_pre   (temp_pre),
        .alarm      (alarm),
        .state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observed();
        return {15'b0, state, pwr, ld, def, sth, alarm, shield_pre, temp_pre};
    endfunction

    function automatic logic [31:0] expected();
        logic [1:0]   s;
        logic         p, l, d, t, a;
        logic [N-1:0] sp, tp;
        s  = 2'(m_mode);
        p  = (m_mode == 2 || m_mode == 3);
        l  = (m_mode == 1);
        a  = (m_mode == 3);
        d  = a || (m_mode == 2 && m_def);
        t  = a || (m_mode == 2 && m_sth);
        sp = (m_mode == 1) ? N'(SH_INIT) : '0;
        tp = (m_mode == 1) ? N'(TP_INIT) : '0;
        return {15'b0, s, p, l, d, t, a, sp, tp};
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_zero_run = 0;
        m_def      = 0;
        m_sth      = 0;
    endtask

    // One clock of the controller described in plain rules.
    task automatic model_step();
        int sh, tp;
        sh = int'(shield_lvl);
        tp = int'(temp_lvl);
        if (!en) begin
            model_reset();
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_mode = 2;
            m_def  = 0;
            m_sth  = 0;
        end else if (m_mode == 2) begin
            if (sh == 0 || tp == 0) m_zero_run = (m_zero_run + 1 > ALARM_CYC) ? ALARM_CYC : m_zero_run + 1;
            else m_zero_run = 0;
            if (sh < SH_LO) m_def = 1;
            else if (sh >= SH_HI) m_def = 0;
            if (tp < TP_LO) m_sth = 1;
            else if (tp >= TP_HI) m_sth = 0;
            if (m_zero_run >= ALARM_CYC) m_mode = 3;
        end else begin
            if (ack && sh >= SH_LO && tp >= TP_LO) begin
                m_mode     = 2;
                m_zero_run = 0;
                m_def      = (sh < SH_LO);
                m_sth      = (tp < TP_LO);
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk(tag, observed(), expected());
    endtask

    function automatic logic [N-1:0] rand_lvl(input int lo, input int hi);
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return N'(lo - 1);
            2:       return N'(lo);
            3:       return N'(hi - 1);
            4:       return N'(hi);
            default: return N'($urandom_range(0, (1 << N) - 1));
        endcase
    endfunction

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        ack        = 1'b0;
        shield_lvl = N'(15);
        temp_lvl   = N'(15);
        model_reset();
        #2;
        chk("reset_outs", observed(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Power-up sequence.
        en         = 1'b1;
        shield_lvl = N'(12);
        cycle("pu_load");
        chk("pu_load_state", 32'(state), 32'd1);
        chk("pu_ld_pulse", {ld, pwr, shield_pre, temp_pre}, {1'b1, 1'b0, 5'd24, 5'd31});
        cycle("pu_reg");
        chk("pu_reg_state", 32'(state), 32'd2);
        chk("pu_reg_pwr_ld", {pwr, ld}, 2'b10);
        cycle("pu_reg2");
        chk("pu_ld_one_cycle", {pwr, ld}, 2'b10);

        // Shield hysteresis sweep.
        shield_lvl = N'(12); cycle("sh12"); chk("def_12", def, 1'b0);
        shield_lvl = N'(7);  cycle("sh7");  chk("def_7", def, 1'b1);
        shield_lvl = N'(15); cycle("sh15"); chk("def_15", def, 1'b1);
        shield_lvl = N'(20); cycle("sh20"); chk("def_20", def, 1'b0);
        shield_lvl = N'(19); cycle("sh19"); chk("def_19", def, 1'b0);

        // Temperature hysteresis.
        temp_lvl = N'(9);  cycle("tp9");  chk("sth_9", sth, 1'b1);
        temp_lvl = N'(21); cycle("tp21"); chk("sth_21", sth, 1'b1);
        temp_lvl = N'(22); cycle("tp22"); chk("sth_22", sth, 1'b0);

        // Three zero cycles then recovery: no alarm.
        temp_lvl = '0;
        for (int i = 0; i < 3; i++) cycle("zero3");
        temp_lvl = N'(5);
        cycle("zero3_recover");
        chk("no_alarm", {state, alarm}, {2'd2, 1'b0});
        temp_lvl = N'(15);
        cycle("tp15");

        // Four zero cycles: alarm.
        temp_lvl = '0;
        for (int i = 0; i < 3; i++) cycle("zero4");
        chk("pre_alarm", 32'(state), 32'd2);
        cycle("zero4_last");
        chk("alarm_entry", {state, alarm, def, sth}, {2'd3, 1'b1, 1'b1, 1'b1});

        // Ack alone with low temperature keeps ALARM; with good levels exits.
        ack = 1'b1; temp_lvl = N'(4); shield_lvl = N'(9);
        cycle("ack_low");
        chk("ack_low_stays", {state, alarm}, {2'd3, 1'b1});
        temp_lvl = N'(12);
        cycle("ack_ok");
        chk("ack_exit", {state, alarm, def, sth}, {2'd2, 1'b0, 1'b0, 1'b0});
        ack = 1'b0;

        // Disable from ALARM.
        temp_lvl = '0;
        for (int i = 0; i < 4; i++) cycle("re_alarm");
        chk("re_alarm_state", 32'(state), 32'd3);
        en = 1'b0;
        cycle("dis_alarm");
        chk("dis_alarm_outs", observed(), 32'd0);

        // en drop on the 4th zero cycle wins over alarm entry.
        en = 1'b1; temp_lvl = N'(15);
        cycle("re_load");
        cycle("re_reg");
        temp_lvl = '0;
        for (int i = 0; i < 3; i++) cycle("zero_pre_dis");
        en = 1'b0;
        cycle("dis_vs_alarm");
        chk("dis_beats_alarm", 32'(state), 32'd0);

        // Asynchronous reset while regulating.
        en = 1'b1; temp_lvl = N'(15);
        cycle("ar_load");
        cycle("ar_reg");
        cycle("ar_reg2");
        chk("ar_pwr_before", pwr, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_outs_immediate", observed(), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("ar_reload");
        chk("ar_reload_ld", {state, ld}, {2'd1, 1'b1});
        cycle("ar_rereg");
        chk("ar_rereg_pwr", {state, pwr}, {2'd2, 1'b1});

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                chk("rnd_async_rst", observed(), 32'd0);
                model_reset();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            en         = ($urandom_range(0, 39) != 0);
            ack        = ($urandom_range(0, 2) == 0);
            shield_lvl = rand_lvl(SH_LO, SH_HI);
            temp_lvl   = rand_lvl(TP_LO, TP_HI);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_support_ctrl.md
# life_support_ctrl

Closed-loop controller that drives the shield/temperature saturation counter in the life-support path. It samples the counter's shield and temperature levels and issues the counter's control strobes: power, load, defend (shield up) and heat (temperature up). It applies hysteresis regulation, loads initial presets on start-up and raises a latched alarm when either level sits at zero too long. It is the command side of the counter interface: it consumes `outshield`/`outtemp` and produces `pwr`/`def`/`sth`/`rst`-load/`shield`/`temp`.

## Interface
Parameters:
- `N`, 5: level width, matches the counter's `n`.
- `SH_INIT`, 24: shield preset driven during LOAD.
- `TP_INIT`, 31: temperature preset driven during LOAD.
- `SH_LO` / `SH_HI`, 8 / 20: shield hysteresis band, with `SH_LO < SH_HI`.
- `TP_LO` / `TP_HI`, 10 / 22: temperature hysteresis band, with `TP_LO < TP_HI`.
- `ALARM_CYC`, 4: consecutive zero-level cycles before ALARM (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: life-support enable request.
- `ack` in 1: operator alarm acknowledge.
- `shield_lvl` in N: counter shield reading.
- `temp_lvl` in N: counter temperature reading.
- `pwr` out 1: counter power.
- `ld` out 1: counter load strobe (drives counter `rst`).
- `def` out 1: shield count-up request.
- `sth` out 1: temperature count-up request.
- `shield_pre` out N: shield preset value.
- `temp_pre` out N: temperature preset value.
- `alarm` out 1: latched alarm.
- `state` out 2: current FSM state.

## Operation
- FSM states: OFF=0, LOAD=1, REG=2, ALARM=3.
- **OFF**: all strobes are 0 and the presets are 0. When `en=1`, go to LOAD.
- **LOAD**: one cycle only.
  - `ld=1`, `pwr=0`, `shield_pre=SH_INIT`, `temp_pre=TP_INIT`.
  - Then go to REG.
- **REG**: `pwr=1`, `ld=0`.
  - Shield hysteresis:
    - `def` sets when `shield_lvl < SH_LO`.
    - `def` clears when `shield_lvl >= SH_HI`.
    - Otherwise `def` holds its value.
  - Temperature hysteresis: `sth` works the same way with `TP_LO`/`TP_HI`.
  - `def` and `sth` are cleared on entry to REG from LOAD.
- **Zero-level fault counter**:
  - Increments each cycle in REG while `shield_lvl==0` or `temp_lvl==0`.
  - Clears on any cycle where both levels are nonzero.
  - Saturates at `ALARM_CYC`.
  - Reaching `ALARM_CYC` moves the FSM to ALARM.
- **ALARM**:
  - `alarm=1`, `pwr=1`, `def=1`, `sth=1`, so both levels are forced upward.
  - Leaves to REG only when `ack=1` and both `shield_lvl>=SH_LO` and `temp_lvl>=TP_LO` in the same cycle.
  - `ack` alone does not exit ALARM; `alarm` stays set.
  - On exit to REG: `alarm` clears, the fault counter clears, and `def`/`sth` re-evaluate from the hysteresis rules starting with the cleared value.
- **`en=0`** in any state other than OFF: go to OFF the next cycle. This overrides all other transitions, including from ALARM, and clears `alarm`.
- **Simultaneous events**:
  - `en` priority beats the ALARM entry condition.
  - In LOAD, the level inputs are ignored.
- Comparisons are unsigned, N bits. No arithmetic beyond the fault counter, which is `$clog2(ALARM_CYC+1)` bits wide.

## Timing
- All outputs are registered. The decision is made from inputs sampled at posedge k, and outputs are visible after posedge k.
- **Latency**: one cycle from a level crossing to the strobe change. The counter responds one further cycle later.
- **Reset**: async assert forces the following immediately, independent of `clk`:
  - `state=OFF`
  - `pwr`, `ld`, `def`, `sth`, `alarm` = 0
  - `shield_pre` = `temp_pre` = 0
  - fault counter = 0
- Reset deassertion is synchronous to `clk` at the system level. The first transition is possible at the first posedge after release.
- **Reset mid-operation** (for example, during ALARM): all state is lost and the next `en` restarts through LOAD.
- **Start-up sequence**: `en` rises at edge k → LOAD at k+1 (`ld` pulse) → REG at k+2 (`pwr=1`).

## Structure
- Package `life_support_pkg` holds:
  - the state enum `ls_state_t` (2 bits, encoding above);
  - the default band constants.
- Sub-module `hyst_ctl`:
  - Parameterised on N, LO and HI.
  - Inputs: `clk`, `rst`, `clr`, `en`, `lvl`. Output: registered `req`.
  - Instantiated twice: shield/`def` and temperature/`sth`.
  - ALARM override and OFF clearing are applied in the top level.

## Test plan
- **Power-up**: reset, then `en=1` → `state` goes 0→1→2 on consecutive edges; `ld=1` for exactly one cycle with `shield_pre=24` and `temp_pre=31`; `pwr=1` from the REG cycle onward.
- **Shield hysteresis**: in REG, sweep `shield_lvl` 12→7→15→20→19 → `def` is 0, 1 (one cycle after 7), 1, 0 (one cycle after 20), 0.
- **Temperature hysteresis**: `temp_lvl` 9 → `sth=1`; 21 → stays 1; 22 → 0 next cycle.
- **Alarm**:
  - `temp_lvl=0` for 4 cycles → `state=3`, `alarm=1`, `def=sth=1`.
  - `temp_lvl=0` for 3 cycles then 5 → no alarm.
  - In ALARM, `ack=1` with `temp_lvl=4` → stays ALARM; `ack=1` with `temp_lvl=12`, `shield_lvl=9` → REG, `alarm=0`.
- **Disable priority**: in ALARM, drop `en` → OFF next cycle, all outputs 0. Dropping `en` in the same cycle as the 4th zero-level cycle → OFF, not ALARM.
- **Async reset**: assert `rst` between edges while in REG → outputs go to 0 immediately, before the next `clk`; re-enable → full LOAD sequence repeats.
